// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: EX-stage operand forwarding select and load-use interlock.
// Keeps a shift-register scoreboard of in-flight writes, one entry per post-EX stage.
module fwd_scoreboard #(
    parameter int AW         = 5,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 2,
    parameter int LOAD_STAGE = 2,
    parameter int CNT_W      = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush,
    input  logic                               ex_valid,
    input  logic                               ex_regwrite,
    input  logic                               ex_memread,
    input  logic [AW-1:0]                      ex_dst,
    input  logic [NUM_SRC*AW-1:0]              ex_src,
    input  logic [NUM_SRC-1:0]                 ex_src_used,
    output logic [NUM_SRC*$clog2(DEPTH+1)-1:0] fwd_sel,
    output logic                               stall,
    output logic [CNT_W-1:0]                   fwd_cnt,
    output logic [CNT_W-1:0]                   stall_cnt
);
    localparam int SEL_W = $clog2(DEPTH+1);

    logic [DEPTH:1]           v;
    logic [DEPTH:1]           ld;
    logic [AW-1:0]            dst [1:DEPTH];
    logic [NUM_SRC*SEL_W-1:0] sel;
    logic                     unready;

    always_comb begin
        sel     = '0;
        stall   = 1'b0;
        unready = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            unready = 1'b0;
            // scan oldest first so the youngest producer is written last
            for (int k = DEPTH; k >= 1; k--) begin
                if (ex_src_used[i] && v[k] && (dst[k] != '0) &&
                    (dst[k] == ex_src[i*AW +: AW])) begin
                    sel[i*SEL_W +: SEL_W] = SEL_W'(k);
                    unready = ld[k] && (k < LOAD_STAGE);
                end
            end
            stall = stall | unready;
        end
    end

    assign fwd_sel = stall ? '0 : sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v         <= '0;
            ld        <= '0;
            fwd_cnt   <= '0;
            stall_cnt <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                dst[k] <= '0;
            end
        end else begin
            if (flush) begin
                v <= '0;
            end else begin
                v[1] <= ex_valid & ex_regwrite & ~stall;
                for (int k = 2; k <= DEPTH; k++) begin
                    v[k] <= v[k-1];
                end
            end
            ld[1]  <= ex_memread;
            dst[1] <= ex_dst;
            for (int k = 2; k <= DEPTH; k++) begin
                ld[k]  <= ld[k-1];
                dst[k] <= dst[k-1];
            end
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (!stall && (|fwd_sel) && (fwd_cnt != '1)) begin
                fwd_cnt <= fwd_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed and random checks of two fwd_scoreboard configs
// against a queue-based model of the in-flight instruction history.
module tb_fwd_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        f0, v0, rw0, mr0;
    logic [4:0]  dst0;
    logic [9:0]  src0;
    logic [1:0]  used0;
    logic [3:0]  sel0;
    logic        st0;
    logic [15:0] fc0, sc0;

    logic        f1, v1, rw1, mr1;
    logic [4:0]  dst1;
    logic [14:0] src1;
    logic [2:0]  used1;
    logic [8:0]  sel1;
    logic        st1;
    logic [1:0]  fc1, sc1;

    fwd_scoreboard d0 (
        .clk(clk), .rst_n(rst_n), .flush(f0), .ex_valid(v0),
        .ex_regwrite(rw0), .ex_memread(mr0), .ex_dst(dst0),
        .ex_src(src0), .ex_src_used(used0), .fwd_sel(sel0),
        .stall(st0), .fwd_cnt(fc0), .stall_cnt(sc0)
    );

    fwd_scoreboard #(
        .AW(5), .NUM_SRC(3), .DEPTH(4), .LOAD_STAGE(3), .CNT_W(2)
    ) d1 (
        .clk(clk), .rst_n(rst_n), .flush(f1), .ex_valid(v1),
        .ex_regwrite(rw1), .ex_memread(mr1), .ex_dst(dst1),
        .ex_src(src1), .ex_src_used(used1), .fwd_sel(sel1),
        .stall(st1), .fwd_cnt(fc1), .stall_cnt(sc1)
    );

    typedef struct {
        bit v;
        int dst;
        bit ld;
    } ent_t;

    // history of instructions that left EX, youngest at index 0
    ent_t q0[$];
    ent_t q1[$];
    int   mfc[2];
    int   msc[2];
    int   ntests = 0;
    int   nfail  = 0;
    int   esel[3];
    bit   est;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(int w, bit fl, bit v, bit rw, bit mr, int d,
                       int s0, int s1, int s2, bit [2:0] u);
        ent_t        q[$];
        ent_t        o[$];
        ent_t        e;
        ent_t        nul;
        int          ns, dep, odep, ls, cmax, s;
        logic [31:0] es;
        bit          any;
        ns   = (w != 0) ? 3 : 2;
        dep  = (w != 0) ? 4 : 2;
        odep = (w != 0) ? 2 : 4;
        ls   = (w != 0) ? 3 : 2;
        cmax = (w != 0) ? 3 : 65535;
        nul  = '{v: 1'b0, dst: 0, ld: 1'b0};
        @(negedge clk);
        if (w == 0) begin
            f0 = fl; v0 = v; rw0 = rw; mr0 = mr; dst0 = d[4:0];
            src0 = {s1[4:0], s0[4:0]}; used0 = u[1:0];
            f1 = 0; v1 = 0; rw1 = 0; mr1 = 0; dst1 = 0; src1 = 0; used1 = 0;
            q = q0; o = q1;
        end else begin
            f1 = fl; v1 = v; rw1 = rw; mr1 = mr; dst1 = d[4:0];
            src1 = {s2[4:0], s1[4:0], s0[4:0]}; used1 = u;
            f0 = 0; v0 = 0; rw0 = 0; mr0 = 0; dst0 = 0; src0 = 0; used0 = 0;
            q = q1; o = q0;
        end
        #1;
        est = 1'b0;
        for (int i = 0; i < 3; i++) begin
            esel[i] = 0;
            s = (i == 0) ? s0 : ((i == 1) ? s1 : s2);
            if (i < ns) begin
                for (int k = 0; k < q.size(); k++) begin
                    if (u[i] && q[k].v && q[k].dst != 0 && q[k].dst == s) begin
                        esel[i] = k + 1;
                        if (q[k].ld && (k + 1 < ls)) est = 1'b1;
                        break;
                    end
                end
            end
        end
        if (est) esel = '{0, 0, 0};
        any = (esel[0] != 0) || (esel[1] != 0) || (esel[2] != 0);
        if (w == 0) begin
            es = 32'({esel[1][1:0], esel[0][1:0]});
            chk("fwd_sel_d0", 32'(sel0), es);
            chk("stall_d0", 32'(st0), 32'(est));
            chk("fwd_cnt_d0", 32'(fc0), mfc[0]);
            chk("stall_cnt_d0", 32'(sc0), msc[0]);
        end else begin
            es = 32'({esel[2][2:0], esel[1][2:0], esel[0][2:0]});
            chk("fwd_sel_d1", 32'(sel1), es);
            chk("stall_d1", 32'(st1), 32'(est));
            chk("fwd_cnt_d1", 32'(fc1), mfc[1]);
            chk("stall_cnt_d1", 32'(sc1), msc[1]);
        end
        if (est) msc[w] = (msc[w] < cmax) ? msc[w] + 1 : cmax;
        else if (any) mfc[w] = (mfc[w] < cmax) ? mfc[w] + 1 : cmax;
        if (fl) begin
            q.delete();
        end else begin
            e = '{v: v && rw && !est, dst: d, ld: mr};
            q.push_front(e);
            while (q.size() > dep) void'(q.pop_back());
        end
        o.push_front(nul);
        while (o.size() > odep) void'(o.pop_back());
        if (w == 0) begin q0 = q; q1 = o; end
        else begin q1 = q; q0 = o; end
    endtask

    task automatic idle(int w, bit fl);
        cyc(w, fl, 0, 0, 0, 0, 0, 0, 0, 3'b000);
    endtask

    initial begin
        rst_n = 0;
        f0 = 0; v0 = 0; rw0 = 0; mr0 = 0; dst0 = 0; src0 = 0; used0 = 0;
        f1 = 0; v1 = 0; rw1 = 0; mr1 = 0; dst1 = 0; src1 = 0; used1 = 0;
        mfc = '{0, 0};
        msc = '{0, 0};
        #1;
        chk("rst_sel0", 32'(sel0), 0);
        chk("rst_st0", 32'(st0), 0);
        chk("rst_fc0", 32'(fc0), 0);
        chk("rst_sc0", 32'(sc0), 0);
        chk("rst_sel1", 32'(sel1), 0);
        chk("rst_st1", 32'(st1), 0);
        chk("rst_fc1", 32'(fc1), 0);
        chk("rst_sc1", 32'(sc1), 0);
        #12 rst_n = 1;

        // back-to-back ALU, then distance 2 and 3
        cyc(0, 0, 1, 1, 0, 3, 0, 0, 0, 3'b000);
        cyc(0, 0, 1, 0, 0, 8, 3, 0, 0, 3'b001);
        chk("b2b_k1", 32'(sel0[1:0]), 1);
        chk("b2b_nostall", 32'(st0), 0);
        cyc(0, 0, 1, 1, 0, 3, 0, 0, 0, 3'b000);
        idle(0, 0);
        cyc(0, 0, 1, 0, 0, 8, 3, 0, 0, 3'b001);
        chk("dist2_k2", 32'(sel0[1:0]), 2);
        cyc(0, 0, 1, 1, 0, 3, 0, 0, 0, 3'b000);
        idle(0, 0);
        idle(0, 0);
        cyc(0, 0, 1, 0, 0, 8, 3, 0, 0, 3'b001);
        chk("dist3_none", 32'(sel0[1:0]), 0);

        // youngest writer wins
        cyc(0, 0, 1, 1, 0, 5, 0, 0, 0, 3'b000);
        cyc(0, 0, 1, 1, 0, 5, 0, 0, 0, 3'b000);
        cyc(0, 0, 1, 0, 0, 8, 5, 5, 0, 3'b011);
        chk("prio_k1", 32'(sel0), 32'h5);

        // load-use: one stall cycle, then stage 2
        cyc(0, 0, 1, 1, 1, 7, 0, 0, 0, 3'b000);
        cyc(0, 0, 1, 0, 0, 8, 7, 0, 0, 3'b001);
        chk("lu_stall", 32'(st0), 1);
        chk("lu_sel0", 32'(sel0), 0);
        cyc(0, 0, 1, 0, 0, 8, 7, 0, 0, 3'b001);
        chk("lu_release", 32'(st0), 0);
        chk("lu_k2", 32'(sel0[1:0]), 2);
        idle(0, 0);
        chk("lu_stall_cnt", 32'(sc0), 1);

        // register 0 and unused operand
        cyc(0, 0, 1, 1, 0, 0, 0, 0, 0, 3'b000);
        cyc(0, 0, 1, 0, 0, 8, 0, 0, 0, 3'b011);
        chk("r0_sel", 32'(sel0), 0);
        chk("r0_stall", 32'(st0), 0);
        cyc(0, 0, 1, 1, 0, 9, 0, 0, 0, 3'b000);
        cyc(0, 0, 1, 0, 0, 8, 1, 9, 0, 3'b001);
        chk("unused_op1", 32'(sel0[3:2]), 0);

        // flush kills a pending load, and overrides a same-cycle issue
        cyc(0, 0, 1, 1, 1, 7, 0, 0, 0, 3'b000);
        idle(0, 1);
        cyc(0, 0, 1, 0, 0, 8, 7, 0, 0, 3'b001);
        chk("flush_ld_stall", 32'(st0), 0);
        chk("flush_ld_sel", 32'(sel0), 0);
        cyc(0, 1, 1, 1, 0, 4, 0, 0, 0, 3'b000);
        cyc(0, 0, 1, 0, 0, 8, 4, 4, 0, 3'b011);
        chk("flush_issue", 32'(sel0), 0);

        // deeper config: two stall cycles on operand 2, then stage 3
        cyc(1, 0, 1, 1, 1, 6, 0, 0, 0, 3'b000);
        cyc(1, 0, 1, 0, 0, 8, 0, 0, 6, 3'b100);
        chk("d1_stall_a", 32'(st1), 1);
        cyc(1, 0, 1, 0, 0, 8, 0, 0, 6, 3'b100);
        chk("d1_stall_b", 32'(st1), 1);
        cyc(1, 0, 1, 0, 0, 8, 0, 0, 6, 3'b100);
        chk("d1_release", 32'(st1), 0);
        chk("d1_k3", 32'(sel1[8:6]), 3);

        // second load-use pair pushes stall_cnt past its 2-bit range
        cyc(1, 0, 1, 1, 1, 6, 0, 0, 0, 3'b000);
        cyc(1, 0, 1, 0, 0, 8, 6, 0, 0, 3'b001);
        cyc(1, 0, 1, 0, 0, 8, 6, 0, 0, 3'b001);
        cyc(1, 0, 1, 0, 0, 8, 6, 0, 0, 3'b001);
        idle(1, 0);
        chk("d1_stall_sat", 32'(sc1), 3);

        // asynchronous reset in the middle of a stall
        cyc(1, 0, 1, 1, 1, 6, 0, 0, 0, 3'b000);
        cyc(1, 0, 1, 0, 0, 8, 6, 0, 0, 3'b001);
        chk("rst_mid_pre", 32'(st1), 1);
        rst_n = 0;
        #1;
        chk("rst_mid_stall", 32'(st1), 0);
        chk("rst_mid_sel", 32'(sel1), 0);
        chk("rst_mid_cnt", 32'(sc1), 0);
        q0.delete();
        q1.delete();
        mfc = '{0, 0};
        msc = '{0, 0};
        #1 rst_n = 1;

        // random traffic on a small register range for frequent hazards
        for (int n = 0; n < 600; n++) begin
            int  w, d, a, b, c;
            bit  vv, fl;
            w  = int'($urandom % 2);
            vv = ($urandom % 4) != 0;
            fl = ($urandom % 16) == 0;
            d  = int'($urandom % 8);
            a  = int'($urandom % 8);
            b  = int'($urandom % 8);
            c  = int'($urandom % 8);
            cyc(w, fl, vv, bit'($urandom % 2), ($urandom % 3) == 0, d, a, b, c,
                vv ? 3'($urandom % 8) : 3'b000);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised EX-stage forwarding and load-use interlock unit for the 5-stage MIPS pipeline and its deeper variants. It owns a shift-register scoreboard of in-flight register writes behind EX, one entry per post-EX stage. From that scoreboard it produces a per-operand forward-select for every ALU source, and a stall when a load result is not yet available. It also keeps saturating forward and stall counters for performance debug. It sits beside the EX stage and drives the ALU source muxes and the ID/EX hold logic.

## Interface
Parameters:
- AW, 5: register address width
- NUM_SRC, 2: source operands per instruction
- DEPTH, 2: scoreboard stages after EX (1 = EX/MEM, 2 = MEM/WB, ...); minimum 1
- LOAD_STAGE, 2: first stage whose load data is forwardable; 1..DEPTH
- CNT_W, 16: performance counter width

Ports (SEL_W = $clog2(DEPTH+1)):
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous; kill all in-flight entries
- ex_valid  in  1  EX holds a real instruction
- ex_regwrite  in  1  EX instruction writes a register
- ex_memread  in  1  EX instruction is a load
- ex_dst  in  AW  EX destination register
- ex_src  in  NUM_SRC*AW  EX source registers; operand i at [i*AW +: AW]
- ex_src_used  in  NUM_SRC  operand i is actually read
- fwd_sel  out  NUM_SRC*SEL_W  per-operand select; 0 = register file, k = stage k result
- stall  out  1  hold EX/ID and insert a bubble behind EX
- fwd_cnt  out  CNT_W  number of cycles with any fwd_sel nonzero, when stall is low
- stall_cnt  out  CNT_W  number of cycles with stall high

## Operation
- Entry k (1..DEPTH) holds {v, dst, ld}. Its occupant is the instruction that was in EX k cycles ago, not counting stalled cycles.
- Each clock, when not flushing: entry k+1 <= entry k. Entry 1 <= {ex_valid & ex_regwrite & ~stall, ex_dst, ex_memread}. A stalled EX instruction therefore enters as a bubble (v=0). The oldest entry drops off.
- An entry is a match for operand i when all of these hold: ex_src_used[i], v=1, dst != 0, dst == ex_src[i].
- Per operand, the lowest-k match wins (youngest producer). fwd_sel[i] = that k, or 0 if there is no match.
- Register 0 is never forwarded and never causes a stall.
- Load-use: if the winning match for any operand has ld=1 and k < LOAD_STAGE, then stall=1. In that case, every fwd_sel is forced to 0 for that cycle.
- An older non-load match does not override a younger unready load. The stall still applies.
- stall and fwd_sel are combinational from registered state and EX inputs. They do not depend on flush.
- flush: all v <= 0 on the next edge. Entry 1 is also cleared, so flush overrides issue.
- Counters saturate at all-ones. Both update on the same edge as the scoreboard.
- Counters are not cleared by flush.
- ex_valid=0 holds no sources. The instantiating logic must drive ex_src_used=0 in that case. The block does not mask it.

## Timing
- Reset (asynchronous, rst_n=0): all v=0, counters=0. This makes fwd_sel=0 and stall=0 immediately, not on an edge.
- Forward latency: a producer in EX at cycle t is selectable as k=1 at t+1 and as k=2 at t+2, and so on. It is gone after t+DEPTH.
- Load stall length: a load-use back-to-back stalls LOAD_STAGE-1 cycles. During that time the load advances and bubbles fill behind it. fwd_sel=LOAD_STAGE on the first non-stalled cycle.
- Simultaneous matches:
  - Both operands matching the same entry each get the same k.
  - Different entries resolve independently per operand.
- Reset mid-stall: stall deasserts at once, and the scoreboard is empty.
- Flush mid-stall: stall deasserts from the cycle after the edge.

## Test plan
- Back-to-back ALU, defaults:
  - Cycle t: EX has add $3 (dst=3, regwrite).
  - Cycle t+1: EX has sub reading $3 on operand 0 -> fwd_sel[0]=1, stall=0, fwd_cnt increments by 1.
  - Same producer with the consumer at t+2 -> fwd_sel=2. Consumer at t+3 -> fwd_sel=0.
- Priority: writes to $5 at t and at t+1, consumer at t+2 -> fwd_sel=1 (the younger writer), not 2.
- Load-use, defaults:
  - lw $7 at t, consumer of $7 at t+1 -> stall=1 for exactly one cycle, fwd_sel=0 during the stall.
  - Next cycle -> stall=0, fwd_sel=2. stall_cnt=1.
- Register 0 and unused operand:
  - A producer writing $0 with a consumer reading $0 -> fwd_sel=0, stall=0.
  - ex_src_used[1]=0 with a matching $rt -> fwd_sel[1]=0.
- Flush:
  - lw $7 in entry 1, flush asserted -> next cycle consumer of $7 sees stall=0, fwd_sel=0.
  - flush asserted together with an issue -> entry 1 stays empty.
- Generalised config, DEPTH=4, LOAD_STAGE=3, NUM_SRC=3:
  - Load then immediate consumer on operand 2 -> stall for 2 cycles, then fwd_sel[2]=3.
  - Counter saturation with CNT_W=2 -> stall_cnt holds at 3.
  - rst_n pulsed mid-stall -> stall=0 asynchronously.
